// File: rtl/arm_mc_controller.sv
// Multicycle control unit for the ARM-subset core: 10-state sequencer, NZCV flags, condition check.
// Define ARM_MC_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR until MemReady is high.
module arm_mc_controller #(
    parameter logic [3:0] FLAG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [1:0] ALUControl,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_ex_q, cond_ex_d;

    logic       mem_go;
`ifdef ARM_MC_MEMWAIT_EN
    assign mem_go = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_go = 1'b1;
`endif

    logic [3:0] cmd;
    logic       dp_valid, dp_arith, is_cmp, rd_pc;
    logic [1:0] dp_ctl;

    assign cmd    = Funct[4:1];
    assign is_cmp = (cmd == 4'b1010);
    assign rd_pc  = (Rd == 4'hF);
    assign State  = state_q;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return ~z;
            4'b0010: return cy;
            4'b0011: return ~cy;
            4'b0100: return n;
            4'b0101: return ~n;
            4'b0110: return v;
            4'b0111: return ~v;
            4'b1000: return cy & ~z;
            4'b1001: return ~cy | z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return ~z & (n == v);
            4'b1101: return z | (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Logical ops leave C,V untouched; unsupported commands execute as NOPs.
    always_comb begin
        dp_valid = 1'b1;
        dp_arith = 1'b1;
        dp_ctl   = 2'b00;
        case (cmd)
            4'b0100: dp_ctl = 2'b00;
            4'b0010: dp_ctl = 2'b01;
            4'b1010: dp_ctl = 2'b01;
            4'b0000: begin dp_ctl = 2'b10; dp_arith = 1'b0; end
            4'b1100: begin dp_ctl = 2'b11; dp_arith = 1'b0; end
            default: begin dp_valid = 1'b0; dp_arith = 1'b0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cond_ex_d  = cond_ex_q;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 2'b00;
        RegSrc     = {Op == 2'b01, Op == 2'b10};
        case (state_q)
            S_FETCH: begin
                IRWrite   = mem_go;
                PCWrite   = mem_go;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_go) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                cond_ex_d = cond_pass(Cond, flags_q);
                case (Op)
                    2'b01:   state_d = S_MEMADR;
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = Funct[3] ? 2'b00 : 2'b01;
                state_d    = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (mem_go) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex_q;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_q;
                if (mem_go) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = dp_ctl;
                if (!dp_valid) begin
                    cond_ex_d = 1'b0;
                end else if (Funct[0] && cond_ex_q) begin
                    flags_d = {ALUFlags[3:2], dp_arith ? ALUFlags[1:0] : flags_q[1:0]};
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = cond_ex_q & ~is_cmp & ~rd_pc;
                PCWrite  = cond_ex_q & ~is_cmp & rd_pc;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_q;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        // NOTE: FETCH is the reset state and would otherwise write PC/IR while reset is held.
        if (reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            flags_q   <= FLAG_RESET;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Scoreboard bench for arm_mc_controller: per-cycle expectations are queued when an
// instruction is driven and compared against the DUT on the falling edge.
module tb_arm_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond, Rd, ALUFlags, State;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl;

    arm_mc_controller #(.FLAG_RESET(4'b0000)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
        .ALUControl(ALUControl), .State(State)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] C_ADR = 7'h01, C_SRCA = 7'h02, C_SRCB = 7'h04, C_RES = 7'h08;
    localparam logic [6:0] C_IMM = 7'h10, C_ALUC = 7'h20, C_REGSRC = 7'h40;

    typedef struct {
        logic [3:0] st;
        logic       pcw, memw, irw, regw, adr, srca;
        logic [1:0] srcb, res, imm, aluc, regsrc;
        logic [6:0] care;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks   = 0;
    int         failures = 0;
    logic [3:0] mflags;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t blank(input logic [3:0] st);
        exp_t e;
        e.st = st; e.pcw = 0; e.memw = 0; e.irw = 0; e.regw = 0; e.adr = 0; e.srca = 0;
        e.srcb = 0; e.res = 0; e.imm = 0; e.aluc = 0; e.regsrc = 0; e.care = 0;
        return e;
    endfunction

    // ARM-style evaluation: base test from cond[3:1], inverted by cond[0].
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: r = 1'b1;
        endcase
        return (c[3:1] == 3'd7) ? ~c[0] : (r ^ c[0]);
    endfunction

    task automatic push_instr(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                              input logic [3:0] rd, input logic [3:0] af, output int n);
        exp_t e;
        logic ce, valid, arith;
        logic [1:0] actl;
        int n0;
        n0 = exp_q.size();
        e = blank(4'd0); e.pcw = 1; e.irw = 1; e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        e.care = C_ADR | C_SRCA | C_SRCB | C_RES | C_ALUC;
        exp_q.push_back(e);
        e = blank(4'd1); e.srca = 1; e.srcb = 2'b10; e.regsrc = {op == 2'b01, op == 2'b10};
        e.care = C_SRCA | C_SRCB | C_ALUC | C_REGSRC;
        exp_q.push_back(e);
        ce = cond_ok(c, mflags);
        case (op)
            2'b01: begin
                e = blank(4'd2); e.srcb = 2'b01; e.imm = 2'b01; e.aluc = fn[3] ? 2'b00 : 2'b01;
                e.care = C_SRCA | C_SRCB | C_IMM | C_ALUC;
                exp_q.push_back(e);
                if (fn[0]) begin
                    e = blank(4'd3); e.adr = 1; e.care = C_ADR;
                    exp_q.push_back(e);
                    e = blank(4'd4); e.res = 2'b01; e.regw = ce; e.care = C_RES;
                    exp_q.push_back(e);
                end else begin
                    e = blank(4'd5); e.adr = 1; e.memw = ce; e.care = C_ADR;
                    exp_q.push_back(e);
                end
            end
            2'b00: begin
                valid = 1; arith = 0; actl = 2'b00;
                case (fn[4:1])
                    4'b0100: begin arith = 1; actl = 2'b00; end
                    4'b0010: begin arith = 1; actl = 2'b01; end
                    4'b1010: begin arith = 1; actl = 2'b01; end
                    4'b0000: actl = 2'b10;
                    4'b1100: actl = 2'b11;
                    default: valid = 0;
                endcase
                e = blank(fn[5] ? 4'd7 : 4'd6); e.srcb = fn[5] ? 2'b01 : 2'b00; e.aluc = actl;
                e.care = C_SRCA | C_SRCB | (fn[5] ? C_IMM : 7'h00) | (valid ? C_ALUC : 7'h00);
                exp_q.push_back(e);
                ce = ce & valid;
                if (ce && fn[0]) mflags = {af[3:2], arith ? af[1:0] : mflags[1:0]};
                e = blank(4'd8); e.care = C_RES;
                e.regw = ce && (fn[4:1] != 4'b1010) && (rd != 4'hF);
                e.pcw  = ce && (fn[4:1] != 4'b1010) && (rd == 4'hF);
                exp_q.push_back(e);
            end
            2'b10: begin
                e = blank(4'd9); e.srcb = 2'b01; e.imm = 2'b10; e.res = 2'b10; e.pcw = ce;
                e.care = C_SRCA | C_SRCB | C_IMM | C_RES | C_ALUC;
                exp_q.push_back(e);
            end
            default: ;
        endcase
        n = exp_q.size() - n0;
    endtask

    task automatic drive(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                         input logic [3:0] rd, input logic [3:0] af);
        Cond = c; Op = op; Funct = fn; Rd = rd; ALUFlags = af;
    endtask

    task automatic run(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                       input logic [3:0] rd, input logic [3:0] af);
        int n;
        drive(c, op, fn, rd, af);
        push_instr(c, op, fn, rd, af, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_hold();
        repeat (3) begin
            @(negedge clk);
            check("rst_state", 32'(State), 32'd0);
            check("rst_wen", 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check("State", 32'(State), 32'(mon_e.st));
            check("wen{PC,Mem,IR,Reg}", 32'({PCWrite, MemWrite, IRWrite, RegWrite}),
                  32'({mon_e.pcw, mon_e.memw, mon_e.irw, mon_e.regw}));
            if ((mon_e.care & C_ADR) != 0)    check("AdrSrc", 32'(AdrSrc), 32'(mon_e.adr));
            if ((mon_e.care & C_SRCA) != 0)   check("ALUSrcA", 32'(ALUSrcA), 32'(mon_e.srca));
            if ((mon_e.care & C_SRCB) != 0)   check("ALUSrcB", 32'(ALUSrcB), 32'(mon_e.srcb));
            if ((mon_e.care & C_RES) != 0)    check("ResultSrc", 32'(ResultSrc), 32'(mon_e.res));
            if ((mon_e.care & C_IMM) != 0)    check("ImmSrc", 32'(ImmSrc), 32'(mon_e.imm));
            if ((mon_e.care & C_ALUC) != 0)   check("ALUControl", 32'(ALUControl), 32'(mon_e.aluc));
            if ((mon_e.care & C_REGSRC) != 0) check("RegSrc", 32'(RegSrc), 32'(mon_e.regsrc));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected summary before t=500000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; MemReady = 1'b1; mflags = 4'b0000;
        drive(4'h0, 2'b00, 6'h00, 4'h0, 4'h0);
        check_reset_hold();

        run(4'hE, 2'b00, 6'b001001, 4'h1, 4'b0110);  // ADDS R1,R2,R3 -> flags 0110
        run(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0);     // BEQ taken
        run(4'h1, 2'b10, 6'b000000, 4'h0, 4'h0);     // BNE not taken
        run(4'h2, 2'b10, 6'b000000, 4'h0, 4'h0);     // BCS taken
        run(4'h8, 2'b10, 6'b000000, 4'h0, 4'h0);     // BHI not taken
        run(4'hE, 2'b00, 6'b110101, 4'h0, 4'b0000);  // CMP imm -> flags 0000
        run(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0);     // BEQ not taken
        run(4'hE, 2'b01, 6'b011001, 4'h4, 4'h0);     // LDR R4,[R5,#8]
        run(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);  // CMP reg -> Z=1
        run(4'h1, 2'b01, 6'b011000, 4'h3, 4'h0);     // STRNE suppressed
        run(4'hE, 2'b01, 6'b010000, 4'h3, 4'h0);     // STR, negative offset
        run(4'hE, 2'b00, 6'b001001, 4'h2, 4'b0001);  // ADDS -> V=1
        run(4'hE, 2'b00, 6'b000001, 4'h2, 4'b1000);  // ANDS keeps C,V -> 1001
        run(4'h6, 2'b10, 6'b000000, 4'h0, 4'h0);     // BVS
        run(4'hA, 2'b10, 6'b000000, 4'h0, 4'h0);     // BGE
        run(4'hB, 2'b10, 6'b000000, 4'h0, 4'h0);     // BLT
        run(4'h4, 2'b10, 6'b000000, 4'h0, 4'h0);     // BMI
        run(4'hE, 2'b00, 6'b011000, 4'hF, 4'h0);     // ORR to PC
        run(4'hE, 2'b00, 6'b000011, 4'h2, 4'b0100);  // unsupported cmd with S: NOP
        run(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0);     // BEQ: Z must still be 0
        run(4'hE, 2'b11, 6'b000000, 4'h0, 4'h0);     // Op=11 NOP
        run(4'hF, 2'b00, 6'b001000, 4'h1, 4'h0);     // cond 1111 never executes
        run(4'hE, 2'b00, 6'b100101, 4'h1, 4'b0011);  // SUBS imm -> flags 0011
        run(4'h9, 2'b10, 6'b000000, 4'h0, 4'h0);     // BLS
        run(4'hD, 2'b10, 6'b000000, 4'h0, 4'h0);     // BLE
        run(4'hC, 2'b10, 6'b000000, 4'h0, 4'h0);     // BGT

        // Set all flags, then reset in the middle of an ADDS.
        run(4'hE, 2'b00, 6'b010101, 4'h0, 4'b1111);
        drive(4'hE, 2'b00, 6'b001001, 4'h2, 4'b1111);
        push_instr(4'hE, 2'b00, 6'b001001, 4'h2, 4'b1111, n);
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        check("pre_reset_execr", 32'(State), 32'd6);
        reset = 1'b1;
        mflags = 4'b0000;
        check_reset_hold();
        run(4'h1, 2'b10, 6'b000000, 4'h0, 4'h0);     // BNE taken: Z cleared by reset
        run(4'h4, 2'b10, 6'b000000, 4'h0, 4'h0);     // BMI not taken: N cleared
        run(4'h2, 2'b10, 6'b000000, 4'h0, 4'h0);     // BCS not taken: C cleared

`ifdef ARM_MC_MEMWAIT_EN
        drive(4'hE, 2'b01, 6'b011001, 4'h4, 4'h0);
        push_instr(4'hE, 2'b01, 6'b011001, 4'h4, 4'h0, n);
        mon_e = exp_q[exp_q.size() - 2];
        exp_q.insert(exp_q.size() - 1, mon_e);
        exp_q.insert(exp_q.size() - 1, mon_e);
        repeat (3) @(posedge clk);
        #1 MemReady = 1'b0;
        repeat (2) @(posedge clk);
        #1 MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`else
        MemReady = 1'b0;
        run(4'hE, 2'b01, 6'b011001, 4'h4, 4'h0);     // MemReady ignored: no stall
        MemReady = 1'b1;
`endif

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
